// File: rtl/accelbrot_com_pkg.sv
// +----------------------------------------------------------------------------+
// | accelbrot_com_pkg                                                          |
// | Shared types and helpers for the accelbrot compute pipeline blocks.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package accelbrot_com_pkg;

    localparam int SIGN_MODE_W = 2;

    typedef enum logic [SIGN_MODE_W-1:0] {
        PASS = 2'd0,
        NEG  = 2'd1,
        ABS  = 2'd2,
        NABS = 2'd3
    } sign_mode_t;

    // Decides whether a number must be negated, given its mode and sign bit.
    function automatic logic negate_needed(input sign_mode_t mode, input logic sign);
        case (mode)
            PASS:    return 1'b0;
            NEG:     return 1'b1;
            ABS:     return sign;
            default: return ~sign;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/accelbrot_com_signop_lane.sv
// +----------------------------------------------------------------------------+
// | accelbrot_com_signop_lane                                                  |
// | One lane: word delay line, MSW sign/zero-low latch, serial negator and     |
// | optional ABS saturation (macro ACCELBROT_COM_SIGNOP_SAT_EN).               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module accelbrot_com_signop_lane
    import accelbrot_com_pkg::*;
#(
    parameter int WWIDTH = 34,
    parameter int NWORDS = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [WWIDTH-1:0] data,
    input  logic              first_word,
    input  logic              last_word,
    input  sign_mode_t        mode,
    input  logic              tail_valid,
    input  logic              tail_start,
    output logic [WWIDTH-1:0] result,
    output logic              ovf
);

`ifdef ACCELBROT_COM_SIGNOP_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic [WWIDTH-1:0] dly [NWORDS];
    logic              zero_acc;
    sign_mode_t        mode_pend;
    // Second copy of per-number state: held until this number's start word
    // leaves the delay line, so the next number's MSW cannot clobber it.
    sign_mode_t        mode_msw;
    logic              sign_msw;
    logic              mostneg_msw;
    logic              neg_r;
    logic              sat_r;
    logic              carry_r;

    logic [WWIDTH-1:0] tail;
    logic              neg_now;
    logic              sat_now;
    logic              carry_now;
    logic [WWIDTH-1:0] res_now;

    always_comb begin
        tail = dly[NWORDS-1];
        if (tail_start) begin
            neg_now   = negate_needed(mode_msw, sign_msw);
            sat_now   = SAT_EN && (mode_msw == ABS) && mostneg_msw;
            carry_now = 1'b1;
        end else begin
            neg_now   = neg_r;
            sat_now   = sat_r;
            carry_now = carry_r;
        end
        // The saturated value of ABS(most-negative) is exactly its bitwise inverse.
        if (sat_now)
            res_now = ~tail;
        else if (neg_now)
            res_now = ~tail + WWIDTH'(carry_now);
        else
            res_now = tail;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NWORDS; i++) dly[i] <= '0;
            zero_acc    <= 1'b0;
            mode_pend   <= PASS;
            mode_msw    <= PASS;
            sign_msw    <= 1'b0;
            mostneg_msw <= 1'b0;
            neg_r       <= 1'b0;
            sat_r       <= 1'b0;
            carry_r     <= 1'b0;
            result      <= '0;
            ovf         <= 1'b0;
        end else begin
            dly[0] <= data;
            for (int i = 1; i < NWORDS; i++) dly[i] <= dly[i-1];

            if (first_word) begin
                mode_pend <= mode;
                zero_acc  <= (data == '0);
            end else begin
                zero_acc  <= zero_acc & (data == '0);
            end

            if (last_word) begin
                mode_msw    <= mode_pend;
                sign_msw    <= data[WWIDTH-1];
                mostneg_msw <= zero_acc && data[WWIDTH-1] && (data[WWIDTH-2:0] == '0);
            end

            if (tail_valid) begin
                result  <= res_now;
                neg_r   <= neg_now;
                sat_r   <= sat_now;
                carry_r <= carry_now & (tail == '0);
                if (tail_start)
                    ovf <= (mode_msw == ABS) && mostneg_msw;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/accelbrot_com_signop.sv
// +----------------------------------------------------------------------------+
// | accelbrot_com_signop                                                       |
// | Multi-lane word-serial PASS/NEG/ABS/NABS with constant NWORDS+1 latency.   |
// | Optional ABS saturation: ACCELBROT_COM_SIGNOP_SAT_EN. Revision: 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module accelbrot_com_signop
    import accelbrot_com_pkg::*;
#(
    parameter int WWIDTH = 34,
    parameter int NWORDS = 4,
    parameter int NCH    = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NCH*WWIDTH-1:0]    in,
    input  logic [NCH*SIGN_MODE_W-1:0] in_mode,
    input  logic                     in_start,
    input  logic                     in_valid,
    output logic [NCH*WWIDTH-1:0]    out,
    output logic                     out_start,
    output logic                     out_valid,
    output logic [NCH-1:0]           out_ovf
);

    localparam int            CW   = $clog2(NWORDS);
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    logic              active;
    logic [CW-1:0]     cnt;
    logic [NWORDS-1:0] vld;
    logic [NWORDS-1:0] st;

    logic              start_w;
    logic              cont_w;
    logic              last_w;
    logic              abort_w;
    logic [NWORDS-2:0] kill;

    always_comb begin
        start_w = in_valid & in_start;
        cont_w  = in_valid & ~in_start & active;
        last_w  = cont_w & (cnt == LAST);
        abort_w = active & (in_start | ~in_valid);
        // The aborted number's words are the newest cnt entries of the delay line.
        kill = '0;
        for (int i = 0; i < NWORDS - 1; i++)
            kill[i] = abort_w && (i < int'(cnt));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            active    <= 1'b0;
            cnt       <= '0;
            vld       <= '0;
            st        <= '0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
        end else begin
            if (start_w) begin
                active <= 1'b1;
                cnt    <= CW'(1);
            end else if (cont_w) begin
                if (cnt == LAST) begin
                    active <= 1'b0;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (abort_w) begin
                active <= 1'b0;
                cnt    <= '0;
            end

            vld       <= {vld[NWORDS-2:0] & ~kill, start_w | cont_w};
            st        <= {st[NWORDS-2:0] & ~kill, start_w};
            out_valid <= vld[NWORDS-1];
            out_start <= vld[NWORDS-1] & st[NWORDS-1];
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        accelbrot_com_signop_lane #(
            .WWIDTH (WWIDTH),
            .NWORDS (NWORDS)
        ) u_lane (
            .clk        (clk),
            .rstn       (rstn),
            .data       (in[c*WWIDTH +: WWIDTH]),
            .first_word (start_w),
            .last_word  (last_w),
            .mode       (sign_mode_t'(in_mode[c*SIGN_MODE_W +: SIGN_MODE_W])),
            .tail_valid (vld[NWORDS-1]),
            .tail_start (vld[NWORDS-1] & st[NWORDS-1]),
            .result     (out[c*WWIDTH +: WWIDTH]),
            .ovf        (out_ovf[c])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_accelbrot_com_signop.sv
// Self-checking bench for accelbrot_com_signop: number-level reference model
// scheduling expected output words, plus directed literal checks.
`default_nettype none

module tb_accelbrot_com_signop;
    import accelbrot_com_pkg::*;

    localparam int W    = 34;
    localparam int NW   = 4;
    localparam int NCH  = 2;
    localparam int N    = W * NW;
    localparam int LAT  = NW + 1;
    localparam int MAXC = 6000;
    localparam logic [N-1:0] MOSTNEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MAXPOS  = {1'b0, {(N-1){1'b1}}};

    logic               clk = 1'b0;
    logic               rstn;
    logic [NCH*W-1:0]   d_in;
    logic [NCH*2-1:0]   d_mode;
    logic               d_start;
    logic               d_valid;
    logic [NCH*W-1:0]   q_out;
    logic               q_start;
    logic               q_valid;
    logic [NCH-1:0]     q_ovf;

    accelbrot_com_signop #(.WWIDTH(W), .NWORDS(NW), .NCH(NCH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in        (d_in),
        .in_mode   (d_mode),
        .in_start  (d_start),
        .in_valid  (d_valid),
        .out       (q_out),
        .out_start (q_start),
        .out_valid (q_valid),
        .out_ovf   (q_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Expected output per cycle index.
    bit               ev_v [MAXC];
    bit               ev_s [MAXC];
    logic [NCH*W-1:0] ev_w [MAXC];
    logic [NCH-1:0]   ev_o [MAXC];

    // Words of the number currently being received.
    logic [N-1:0]     bx [NCH];
    logic [NCH*2-1:0] bmode;
    int               bn = 0;
    int               bcyc = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_op(input logic [1:0] m, input logic [N-1:0] x, output bit ovf);
        logic [N-1:0] r;
        ovf = (m == 2'd2) && (x == MOSTNEG);
        case (m)
            2'd0:    r = x;
            2'd1:    r = -x;
            2'd2:    r = x[N-1] ? -x : x;
            default: r = x[N-1] ? x : -x;
        endcase
`ifdef ACCELBROT_COM_SIGNOP_SAT_EN
        if (ovf) r = MAXPOS;
`endif
        return r;
    endfunction

    task automatic schedule();
        logic [N-1:0]   r [NCH];
        logic [NCH-1:0] ro;
        bit             o;
        for (int c = 0; c < NCH; c++) begin
            r[c]  = ref_op(bmode[c*2 +: 2], bx[c], o);
            ro[c] = o;
        end
        for (int k = 0; k < NW; k++) begin
            int e = bcyc + LAT + k;
            if (e < MAXC) begin
                ev_v[e] = 1'b1;
                ev_s[e] = (k == 0);
                for (int c = 0; c < NCH; c++) ev_w[e][c*W +: W] = r[c][k*W +: W];
                ev_o[e] = ro;
            end
        end
    endtask

    // Drive one cycle of inputs and advance the model by the framing rules.
    task automatic send(input bit rs, input bit v, input bit s,
                        input logic [NCH*W-1:0] w, input logic [NCH*2-1:0] m);
        rstn = rs; d_valid = v; d_start = s; d_in = w; d_mode = m;
        if (!rs) begin
            bn = 0;
            for (int e = cyc + 1; e < MAXC; e++) begin
                ev_v[e] = 1'b0; ev_s[e] = 1'b0; ev_w[e] = '0; ev_o[e] = '0;
            end
        end else if (v && (s || bn > 0)) begin
            if (s) begin
                bn = 0; bcyc = cyc; bmode = m;
            end
            for (int c = 0; c < NCH; c++) bx[c][bn*W +: W] = w[c*W +: W];
            bn++;
            if (bn == NW) begin
                schedule();
                bn = 0;
            end
        end else if (!v) begin
            bn = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic send_num(input logic [N-1:0] x0, input logic [N-1:0] x1,
                            input logic [1:0] m0, input logic [1:0] m1);
        for (int k = 0; k < NW; k++)
            send(1'b1, 1'b1, k == 0, {x1[k*W +: W], x0[k*W +: W]}, {m1, m0});
    endtask

    function automatic logic [N-1:0] rand_val();
        logic [159:0] t;
        int           s;
        logic [N-1:0] v;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        s = int'($urandom_range(0, 20)) - 10;
        case ($urandom_range(0, 6))
            0, 1:    v = t[N-1:0];
            2:       v = MOSTNEG;
            3:       v = '0;
            4:       v = '1;
            5:       v = {{(N-32){s[31]}}, s};
            default: v = MOSTNEG | N'(1);
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            check("out_valid", N'(q_valid), N'(ev_v[cyc]));
            if (ev_v[cyc]) begin
                check("out_start", N'(q_start), N'(ev_s[cyc]));
                for (int c = 0; c < NCH; c++)
                    check($sformatf("lane%0d_word", c), N'(q_out[c*W +: W]), N'(ev_w[cyc][c*W +: W]));
                check("out_ovf", N'(q_ovf), N'(ev_o[cyc]));
            end
        end
    end

    initial begin : driver
        logic [N-1:0] r;
        logic [N-1:0] neg2;
        bit           o;
        int           t0;
        for (int e = 0; e < MAXC; e++) begin
            ev_v[e] = 1'b0; ev_s[e] = 1'b0; ev_w[e] = '0; ev_o[e] = '0;
        end
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 1'b0, '0, '0);
        chk_en = 1'b1;
        check("reset_out", N'(q_out), N'(0));
        check("reset_flags", N'({q_valid, q_start, q_ovf}), N'(0));

        // Pin the model with hand-computed values.
        r = ref_op(2'd1, N'(5), o);
        check("model_neg5_w0", N'(r[W-1:0]), N'(34'h3FFFFFFFB));
        check("model_neg5_w3", N'(r[N-1 -: W]), N'(34'h3FFFFFFFF));
        r = ref_op(2'd2, '1, o);
        check("model_abs_m1", r, N'(1));
        r = ref_op(2'd3, N'(3), o);
        check("model_nabs3_w0", N'(r[W-1:0]), N'(34'h3FFFFFFFD));
        r = ref_op(2'd2, MOSTNEG, o);
        check("model_mostneg_ovf", N'(o), N'(1));
`ifdef ACCELBROT_COM_SIGNOP_SAT_EN
        check("model_mostneg_w3", N'(r[N-1 -: W]), N'(34'h1FFFFFFFF));
        check("model_mostneg_w0", N'(r[W-1:0]), N'(34'h3FFFFFFFF));
`else
        check("model_mostneg_wrap", r, MOSTNEG);
`endif

        // NEG(+5) on lane 0 alongside PASS(9) on lane 1.
        t0 = cyc;
        send_num(N'(5), N'(9), NEG, PASS);
        while (cyc < t0 + LAT) idle(1);
        check("dut_neg5_start", N'({q_valid, q_start}), N'(2'b11));
        check("dut_neg5_w0", N'(q_out[W-1:0]), N'(34'h3FFFFFFFB));
        check("dut_pass9_w0", N'(q_out[2*W-1:W]), N'(9));
        idle(4);

        send_num('1, N'(7), ABS, ABS);
        idle(2);

        // Back-to-back PASS x, ABS(-2), NABS(+3) on lane 0.
        neg2 = {N{1'b1}} - 1;
        t0 = cyc;
        send_num(rand_val(), rand_val(), PASS, NEG);
        send_num(neg2, rand_val(), ABS, NABS);
        send_num(N'(3), rand_val(), NABS, ABS);
        idle(1);
        check("dut_b2b_nabs3_w0", N'(q_out[W-1:0]), N'(34'h3FFFFFFFD));
        check("dut_b2b_valid", N'({q_valid, q_start}), N'(2'b11));
        idle(5);

        // ABS of the most-negative value.
        t0 = cyc;
        send_num(MOSTNEG, '0, ABS, NABS);
        idle(1);
        check("dut_mostneg_ovf", N'(q_ovf[0]), N'(1));
`ifdef ACCELBROT_COM_SIGNOP_SAT_EN
        check("dut_mostneg_w0", N'(q_out[W-1:0]), N'(34'h3FFFFFFFF));
`else
        check("dut_mostneg_w0", N'(q_out[W-1:0]), N'(0));
`endif
        idle(5);

        // Restart at word 2: the two aborted words must never emerge.
        t0 = cyc;
        send(1'b1, 1'b1, 1'b1, {34'h1, 34'h2}, {NEG, NEG});
        send(1'b1, 1'b1, 1'b0, {34'h3, 34'h4}, {NEG, NEG});
        send_num(N'(11), N'(12), NEG, ABS);
        check("dut_abort_hidden", N'(q_valid), N'(0));
        idle(1);
        check("dut_restart_start", N'({q_valid, q_start}), N'(2'b11));
        idle(4);

        // Abort by a gap, then stray words without a start.
        send(1'b1, 1'b1, 1'b1, {34'h5, 34'h6}, {ABS, ABS});
        send(1'b1, 1'b1, 1'b0, {34'h7, 34'h8}, {ABS, ABS});
        send(1'b1, 1'b1, 1'b0, {34'h9, 34'hA}, {ABS, ABS});
        idle(1);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b0, {34'hB, 34'hC}, {NEG, NEG});
        idle(LAT + 1);

        // Reset during word 1.
        send_num(N'(21), N'(22), NEG, NEG);
        t0 = cyc;
        send(1'b1, 1'b1, 1'b1, {34'h1, 34'h1}, {NEG, NEG});
        send(1'b0, 1'b1, 1'b0, {34'h0, 34'h0}, {NEG, NEG});
        check("dut_rst_out", N'(q_out), N'(0));
        check("dut_rst_flags", N'({q_valid, q_start, q_ovf}), N'(0));
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b0, {34'h1, 34'h1}, {NEG, NEG});
        send_num(N'(31), MOSTNEG, ABS, ABS);
        idle(LAT);

        // Randomized numbers with gaps, aborts, strays and occasional resets.
        for (int n = 0; n < 300 && cyc < MAXC - 60; n++) begin
            int p;
            case ($urandom_range(0, 19))
                0, 1: begin
                    p = $urandom_range(1, NW - 1);
                    send(1'b1, 1'b1, 1'b1, {$urandom(), $urandom(), $urandom()}, 4'($urandom()));
                    for (int k = 1; k < p; k++)
                        send(1'b1, 1'b1, 1'b0, {$urandom(), $urandom(), $urandom()}, 4'($urandom()));
                    if ($urandom_range(0, 1) == 1) idle(1);
                end
                2: send(1'b1, 1'b1, 1'b0, {$urandom(), $urandom(), $urandom()}, 4'($urandom()));
                3: send(1'b0, 1'($urandom()), 1'($urandom()), '0, '0);
                default: ;
            endcase
            send_num(rand_val(), rand_val(), 2'($urandom()), 2'($urandom()));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(LAT + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
